tmds_pll_supervisor: RTL
========================

// Module: tmds_pll_supervisor
// PURPOSE
//  Sequences and supervises the TMDS serial-clock PLL. It drives the PLL reset and watches the
//  PLL lock output. It releases a clean, registered active-low reset to the HDMI/pixel logic
//  only after lock has been stable, and re-initialises the PLL on lock timeout or lock loss.
//  Runs on the 27 MHz board clock that also feeds the PLL input.
// PARAMETERS
//  RESET_CYCLES        16      cycles pll_reset is held high per PLL reset pulse (>=1)
//  LOCK_TIMEOUT_CYCLES 270000  max cycles to wait for lock after the pulse (10 ms @ 27 MHz)
//  STABLE_CYCLES       2700    consecutive synced-lock cycles required before release (100 us)
//  LOSS_FILTER         4       consecutive synced-lock-low cycles in RUN treated as lock loss
//  MAX_RETRIES         7       consecutive failed attempts before FAULT; 0 = retry forever
// PORTS
//  clk         in   1  27 MHz reference clock
//  rst_n       in   1  asynchronous active-low reset
//  pll_lock    in   1  PLL lock, asynchronous to clk
//  pll_reset   out  1  active-high reset to the PLL
//  sys_rst_n   out  1  active-low reset to TMDS/pixel logic (registered)
//  ready       out  1  high while in RUN
//  fault       out  1  sticky; retries exhausted
//  loss_count  out  8  cumulative lock-loss events in RUN, saturates at 255
// BEHAVIOUR
//  - One clock, asynchronous active-low reset. Every output and state flop is registered.
//  - rst_n low forces these values immediately:
//    - pll_reset=1, sys_rst_n=0, ready=0, fault=0, loss_count=0.
//    - Synchronizer=0, fail_cnt=0, state=RST_PLL, timer=0.
//  - pll_lock passes through a 2-FF synchronizer, giving lock_s. lock_s is the only lock source.
//  - States RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT:
//    - RST_PLL: pll_reset=1 for exactly RESET_CYCLES cycles, then WAIT_LOCK with timer=0.
//    - WAIT_LOCK: pll_reset=0.
//      - lock_s=1 -> STABLE, timer=0.
//      - Timer reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0 -> RETRY.
//    - STABLE: counts consecutive lock_s=1 cycles.
//      - Count reaches STABLE_CYCLES -> RUN.
//      - Any lock_s=0 -> RETRY.
//    - RUN: sys_rst_n=1, ready=1, and fail_cnt is cleared on entry.
//      - lock_s low for LOSS_FILTER consecutive cycles -> loss_count+1 (saturating), then RETRY.
//      - Shorter low runs are ignored, and the filter counter resets on lock_s=1.
//    - RETRY (a transition, not a state):
//      - If MAX_RETRIES!=0 and fail_cnt==MAX_RETRIES -> FAULT.
//      - Otherwise fail_cnt+1 -> RST_PLL.
//    - FAULT: pll_reset=1, sys_rst_n=0, ready=0, fault=1. Held until rst_n.
//  - Output timing:
//    - sys_rst_n/ready rise on the same edge the state register becomes RUN.
//    - sys_rst_n/ready fall on the same edge the state leaves RUN.
//    - pll_reset rises on that same edge.
//  - Release latency, lock steady from WAIT_LOCK: 2 sync cycles + 1 (enter STABLE)
//    + STABLE_CYCLES edges.
//  - Counter widths: timer is $clog2(max(LOCK_TIMEOUT_CYCLES, STABLE_CYCLES, RESET_CYCLES))+1 bits.
//    fail_cnt is $clog2(MAX_RETRIES+1)+1 bits and saturates.
//  - A lock glitch in the same cycle as a timer terminal count: the lock condition wins.
//    - In WAIT_LOCK, lock_s=1 at timeout goes to STABLE.
//    - In STABLE, lock_s=0 at terminal count goes to RETRY.
//  - rst_n assertion mid-operation, including RUN: all outputs return to reset values
//    asynchronously, and the full sequence restarts from RST_PLL.
// STRUCTURE
//  - Shared package clk_pkg holds:
//    - State encodings (localparam, 3 bits): ST_RST_PLL=0, ST_WAIT_LOCK=1, ST_STABLE=2,
//      ST_RUN=3, ST_FAULT=4.
//    - Default timing constants in 27 MHz cycles.
//  - One sub-module, sync_2ff: a generic 2-flop synchronizer with async active-low reset,
//    reset value 0. It is reused for other CDC single bits.
//  - FSM, shared timer, filter counter and fail/loss counters stay in this module.
// TESTING (RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, STABLE_CYCLES=10, LOSS_FILTER=3, MAX_RETRIES=2)
//  1. Release rst_n; raise pll_lock 20 cycles after pll_reset falls and hold it
//     -> pll_reset high exactly 4 cycles.
//     -> sys_rst_n and ready rise 13 edges after the pll_lock rise.
//     -> fault=0, loss_count=0.
//  2. pll_lock tied 0 -> three 4-cycle pll_reset pulses, 100 cycles apart plus the pulse.
//     -> After the third timeout, fault=1 and pll_reset stuck at 1. sys_rst_n never rises.
//  3. In RUN, drop pll_lock for 2 cycles -> no output change.
//     -> Drop it for 3 cycles: sys_rst_n=0, ready=0, loss_count=1, then a 4-cycle pll_reset pulse.
//     -> With the lock restored, RUN is re-entered.
//  4. In STABLE, drop pll_lock 1 cycle at stable count 5 -> pll_reset re-pulses, sys_rst_n stays 0.
//     -> A clean lock afterwards reaches RUN, and fail_cnt is cleared.
//  5. Assert rst_n mid-RUN, asynchronously between clk edges
//     -> pll_reset=1, sys_rst_n=0, ready=0, loss_count=0 before the next edge.
//     -> Release restarts the scenario 1 timing.
//  6. Force 300 lock-loss events in RUN -> loss_count saturates at 255, no wrap, fault stays 0.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared clocking/reset package: FSM state encodings, default timing constants
// in 27 MHz reference-clock cycles, and a small elaboration-time helper.
package clk_pkg;

  // Supervisor states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Default timing, 27 MHz cycles.
  localparam int DEF_RESET_CYCLES        = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 270000;  // 10 ms
  localparam int DEF_STABLE_CYCLES       = 2700;    // 100 us
  localparam int DEF_LOSS_FILTER         = 4;
  localparam int DEF_MAX_RETRIES         = 7;

  localparam int LOSS_COUNT_W = 8;

  // Largest of three values, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for single-bit (or independent multi-bit) CDC.
// Asynchronous active-low reset, reset value 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Two-stage capture of each asynchronous bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/tmds_pll_supervisor.sv
// TMDS PLL supervisor: pulses the PLL reset, waits for lock, qualifies it as
// stable, then releases a registered reset to the pixel/HDMI logic. Lock
// timeouts, glitches during qualification and filtered lock loss in RUN all
// re-initialise the PLL; too many consecutive failures park it in FAULT.
module tmds_pll_supervisor
  import clk_pkg::*;
#(
  parameter int RESET_CYCLES        = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int LOSS_FILTER         = DEF_LOSS_FILTER,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_lock,
  output logic                    pll_reset,
  output logic                    sys_rst_n,
  output logic                    ready,
  output logic                    fault,
  output logic [LOSS_COUNT_W-1:0] loss_count
);

  // One timer is shared by RST_PLL, WAIT_LOCK and STABLE, so it is sized for
  // the longest of the three intervals.
  localparam int TIMER_W = $clog2(max3(LOCK_TIMEOUT_CYCLES, STABLE_CYCLES, RESET_CYCLES)) + 1;
  localparam int FAIL_W  = $clog2(MAX_RETRIES + 1) + 1;
  localparam int FILT_W  = $clog2(LOSS_FILTER) + 1;

  localparam logic [TIMER_W-1:0]      RESET_LAST  = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0]      LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0]      STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [FILT_W-1:0]       FILT_LAST   = FILT_W'(LOSS_FILTER - 1);
  localparam logic [FAIL_W-1:0]       FAIL_LIMIT  = FAIL_W'(MAX_RETRIES);
  localparam logic [FAIL_W-1:0]       FAIL_SAT    = '1;
  localparam logic [LOSS_COUNT_W-1:0] LOSS_SAT    = '1;

  logic lock_s;

  state_t                  state_reg, state_next;
  logic [TIMER_W-1:0]      timer_reg, timer_next;
  logic [FILT_W-1:0]       filt_reg, filt_next;
  logic [FAIL_W-1:0]       fail_reg, fail_next;
  logic [LOSS_COUNT_W-1:0] loss_reg, loss_next;
  logic                    retry;

  logic pll_reset_reg, pll_reset_next;
  logic sys_rst_n_reg, sys_rst_n_next;
  logic ready_reg, ready_next;
  logic fault_reg, fault_next;

  // pll_lock is asynchronous to clk; lock_s is the only lock source used below.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state, counter and output decode; lock conditions take priority over
  // terminal counts in the same cycle.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    filt_next  = '0;
    fail_next  = fail_reg;
    loss_next  = loss_reg;
    retry      = 1'b0;

    case (state_reg)
      ST_RST_PLL: begin
        if (timer_reg == RESET_LAST) begin
          state_next = ST_WAIT_LOCK;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
          timer_next = '0;
        end else if (timer_reg == LOCK_LAST) begin
          retry = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          retry = 1'b1;
        end else if (timer_reg == STABLE_LAST) begin
          state_next = ST_RUN;
          timer_next = '0;
          fail_next  = '0;  // a successful bring-up ends the failure streak
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_RUN: begin
        // Short lock dropouts are tolerated; only a run of LOSS_FILTER lows counts.
        if (!lock_s) begin
          if (filt_reg == FILT_LAST) begin
            retry = 1'b1;
            if (loss_reg != LOSS_SAT) begin
              loss_next = loss_reg + 1'b1;
            end
          end else begin
            filt_next = filt_reg + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_RST_PLL;
        timer_next = '0;
      end
    endcase

    // Every failed attempt funnels through here: either another PLL reset
    // pulse or, once the retry budget is spent, a permanent fault.
    if (retry) begin
      timer_next = '0;
      if ((MAX_RETRIES != 0) && (fail_reg == FAIL_LIMIT)) begin
        state_next = ST_FAULT;
      end else begin
        state_next = ST_RST_PLL;
        if (fail_reg != FAIL_SAT) begin
          fail_next = fail_reg + 1'b1;
        end
      end
    end

    // Outputs are decoded from the next state so they switch on the same edge
    // as the state register.
    pll_reset_next = (state_next == ST_RST_PLL) || (state_next == ST_FAULT);
    sys_rst_n_next = (state_next == ST_RUN);
    ready_next     = (state_next == ST_RUN);
    fault_next     = (state_next == ST_FAULT);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RST_PLL;
      timer_reg <= '0;
      filt_reg  <= '0;
      fail_reg  <= '0;
      loss_reg  <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      filt_reg  <= filt_next;
      fail_reg  <= fail_next;
      loss_reg  <= loss_next;
    end
  end

  // Registered outputs; reset holds the PLL in reset and the pixel logic off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset_reg <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      pll_reset_reg <= pll_reset_next;
      sys_rst_n_reg <= sys_rst_n_next;
      ready_reg     <= ready_next;
      fault_reg     <= fault_next;
    end
  end

  assign pll_reset  = pll_reset_reg;
  assign sys_rst_n  = sys_rst_n_reg;
  assign ready      = ready_reg;
  assign fault      = fault_reg;
  assign loss_count = loss_reg;

endmodule
